random_range_gen: RTL



---
 rtl/random_range_gen_if.sv | 26 ++
 rtl/random_range_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/random_range_gen_if.sv
// Request/draw bus for random_range_gen: seeding, free-run enable and the
// req/ready/valid bounded-draw handshake.
interface random_range_gen_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 4
);
  logic             i_en;
  logic             i_seed_load;
  logic [WIDTH-1:0] i_seed;
  logic             i_req;
  logic [OUT_W-1:0] i_range;
  logic             o_ready;
  logic             o_valid;
  logic [OUT_W-1:0] o_random;
  logic [OUT_W-1:0] o_raw;

  modport master (
    output i_en, i_seed_load, i_seed, i_req, i_range,
    input  o_ready, o_valid, o_random, o_raw
  );

  modport slave (
    input  i_en, i_seed_load, i_seed, i_req, i_range,
    output o_ready, o_valid, o_random, o_raw
  );
endinterface

// File: rtl/random_range_gen.sv
// XNOR-LFSR random source with rejection-sampled draws in [0, range).
// Optional lockup guard: define RANDOM_RANGE_GEN_LOCKUP_GUARD_EN.
module random_range_gen #(
  parameter int               WIDTH        = 16,
  parameter int               OUT_W        = 4,
  parameter int               MAX_TRIES    = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'('hACE1)
) (
  input logic               i_clk,
  input logic               i_rst_n,
  random_range_gen_if.slave bus
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  function automatic logic [31:0] taps_for(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps_for(WIDTH));

  generate
    if (WIDTH != 8 && WIDTH != 16 && WIDTH != 24 && WIDTH != 32) begin : g_bad_width
      $error("random_range_gen: WIDTH must be 8, 16, 24 or 32");
    end
    if (OUT_W > WIDTH || OUT_W < 1) begin : g_bad_out_w
      $error("random_range_gen: OUT_W must be 1..WIDTH");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
      $error("random_range_gen: MAX_TRIES must be >= 1");
    end
    if (DEFAULT_SEED == '1) begin : g_bad_seed
      $error("random_range_gen: DEFAULT_SEED must not be all-ones");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, seed_val, step_val;
  logic [OUT_W-1:0] range_q, reff_in, lim, mask, cand, random_q;
  logic [TRY_W-1:0] tries_q;
  logic             fb, lockup, step, eval, hit, last_try;

  // All-ones is the XNOR lockup state; the guard steers out of it.
`ifdef RANDOM_RANGE_GEN_LOCKUP_GUARD_EN
  assign lockup   = &lfsr_q;
  assign seed_val = (&bus.i_seed) ? DEFAULT_SEED : bus.i_seed;
`else
  assign lockup   = 1'b0;
  assign seed_val = bus.i_seed;
`endif

  assign fb       = ~^(lfsr_q & TAPS);
  assign step_val = lockup ? DEFAULT_SEED : {lfsr_q[WIDTH-2:0], fb};
  assign step     = bus.i_en || (state_q == DRAW);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)             lfsr_q <= '0;
    else if (bus.i_seed_load) lfsr_q <= seed_val;
    else if (step)            lfsr_q <= step_val;
  end

  // Mask = smallest 2^k-1 covering range-1, from the latched range.
  assign reff_in = (bus.i_range == '0) ? OUT_W'(1) : bus.i_range;
  assign lim     = range_q - OUT_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < OUT_W; i++) mask[i] = |(lim >> i);
  end

  assign cand     = lfsr_q[OUT_W-1:0] & mask;
  assign hit      = (cand < range_q);
  assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));
  // Seed loads and forced lockup exits do not consume an attempt.
  assign eval     = (state_q == DRAW) && !bus.i_seed_load && !lockup;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_req) state_d = DRAW;
      DRAW:    if (eval && (hit || last_try)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_valid = (state_q == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      range_q  <= '0;
      tries_q  <= '0;
      random_q <= '0;
    end else if (state_q == IDLE && bus.i_req) begin
      range_q <= reff_in;
      tries_q <= '0;
    end else if (eval) begin
      // Fallback cand-range is in range since mask < 2*range.
      if (hit)           random_q <= cand;
      else if (last_try) random_q <= cand - range_q;
      else               tries_q  <= tries_q + TRY_W'(1);
    end
  end

  assign bus.o_random = random_q;
  assign bus.o_raw    = lfsr_q[OUT_W-1:0];

endmodule
